// File: rtl/mem_responder_if.sv
// Bus bundle between the cache-side master and the memory/UART responder.
// Clock and reset stay outside as plain ports.
interface mem_responder_if;
  logic        rdy;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        halt;

  modport slave (
    input  rdy, mem_a, mem_dout, mem_wr, tx_ready, rx_data, rx_valid,
    output mem_din, io_buffer_full, tx_data, tx_valid, halt
  );

  modport master (
    output rdy, mem_a, mem_dout, mem_wr, tx_ready, rx_data, rx_valid,
    input  mem_din, io_buffer_full, tx_data, tx_valid, halt
  );
endinterface

// File: rtl/mem_responder.sv
// Byte-wide memory responder: RAM region plus a UART-style I/O window
// with TX/RX FIFOs, status register and a sticky halt flag.
module mem_responder #(
  parameter int ADDR_WIDTH = 17,
  parameter int TX_DEPTH   = 8,
  parameter int RX_DEPTH   = 8
) (
  input logic            clk,
  input logic            rst,
  mem_responder_if.slave bus
);

  localparam int TXW = $clog2(TX_DEPTH);
  localparam int RXW = $clog2(RX_DEPTH);
  localparam logic [TXW:0] TX_FULL = (TXW+1)'(TX_DEPTH);
  localparam logic [TXW:0] TX_HIGH = (TXW+1)'(TX_DEPTH - 2);
  localparam logic [RXW:0] RX_FULL = (RXW+1)'(RX_DEPTH);

  logic [7:0] ram [0:(2**ADDR_WIDTH)-1];
  logic [7:0] tx_mem [0:TX_DEPTH-1];
  logic [7:0] rx_mem [0:RX_DEPTH-1];

  logic [7:0]   mem_din_q, mem_din_d;
  logic         iobf_q, iobf_d;
  logic         halt_q, halt_d;
  logic         tx_ovf_q, tx_ovf_d;
  logic         rx_ovf_q, rx_ovf_d;
  logic [TXW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [TXW:0]   tx_cnt_q, tx_cnt_d;
  logic [RXW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [RXW:0]   rx_cnt_q, rx_cnt_d;

  logic [17:0]           a18;
  logic [ADDR_WIDTH-1:0] ram_idx;
  logic                  io_sel, acc_data, acc_stat, ram_we;
  logic                  tx_pop, tx_push_req, tx_push;
  logic                  rx_pop, rx_push;
  logic                  unused_hi;

  assign a18       = bus.mem_a[17:0];
  assign ram_idx   = bus.mem_a[ADDR_WIDTH-1:0];
  assign unused_hi = ^bus.mem_a[31:18];
  assign io_sel    = (a18[17:16] == 2'b11);
  assign acc_data  = bus.rdy && (a18 == 18'h30000);
  assign acc_stat  = bus.rdy && (a18 == 18'h30004);
  assign ram_we    = bus.rdy && bus.mem_wr && !io_sel;

  assign bus.tx_valid       = (tx_cnt_q != '0);
  assign bus.tx_data        = bus.tx_valid ? tx_mem[tx_rd_q] : 8'h00;
  assign bus.mem_din        = mem_din_q;
  assign bus.io_buffer_full = iobf_q;
  assign bus.halt           = halt_q;

  always_comb begin
    mem_din_d = mem_din_q;
    halt_d    = halt_q;
    tx_ovf_d  = tx_ovf_q;
    rx_ovf_d  = rx_ovf_q;

    // A pop frees a slot in the same cycle, so a full FIFO can still accept.
    tx_pop      = bus.tx_valid && bus.tx_ready;
    tx_push_req = acc_data && bus.mem_wr;
    tx_push     = tx_push_req && ((tx_cnt_q != TX_FULL) || tx_pop);
    if (tx_push_req && !tx_push) tx_ovf_d = 1'b1;

    rx_pop  = acc_data && !bus.mem_wr && (rx_cnt_q != '0);
    rx_push = bus.rx_valid && ((rx_cnt_q != RX_FULL) || rx_pop);
    if (bus.rx_valid && !rx_push) rx_ovf_d = 1'b1;

    if (acc_stat && bus.mem_wr) halt_d = 1'b1;

    if (bus.rdy) begin
      if (bus.mem_wr)     mem_din_d = 8'h00;
      else if (!io_sel)   mem_din_d = ram[ram_idx];
      else if (acc_data)  mem_din_d = (rx_cnt_q != '0) ? rx_mem[rx_rd_q] : 8'h00;
      else if (acc_stat)  mem_din_d = {5'b0, rx_ovf_q, tx_ovf_q, rx_cnt_q != '0};
      else                mem_din_d = 8'h00;
    end

    tx_wr_d  = tx_wr_q + TXW'(tx_push);
    tx_rd_d  = tx_rd_q + TXW'(tx_pop);
    tx_cnt_d = tx_cnt_q + (TXW+1)'(tx_push) - (TXW+1)'(tx_pop);
    rx_wr_d  = rx_wr_q + RXW'(rx_push);
    rx_rd_d  = rx_rd_q + RXW'(rx_pop);
    rx_cnt_d = rx_cnt_q + (RXW+1)'(rx_push) - (RXW+1)'(rx_pop);

    iobf_d = (tx_cnt_d >= TX_HIGH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_din_q <= 8'h00;
      iobf_q    <= 1'b0;
      halt_q    <= 1'b0;
      tx_ovf_q  <= 1'b0;
      rx_ovf_q  <= 1'b0;
      tx_wr_q   <= '0;
      tx_rd_q   <= '0;
      tx_cnt_q  <= '0;
      rx_wr_q   <= '0;
      rx_rd_q   <= '0;
      rx_cnt_q  <= '0;
    end else begin
      mem_din_q <= mem_din_d;
      iobf_q    <= iobf_d;
      halt_q    <= halt_d;
      tx_ovf_q  <= tx_ovf_d;
      rx_ovf_q  <= rx_ovf_d;
      tx_wr_q   <= tx_wr_d;
      tx_rd_q   <= tx_rd_d;
      tx_cnt_q  <= tx_cnt_d;
      rx_wr_q   <= rx_wr_d;
      rx_rd_q   <= rx_rd_d;
      rx_cnt_q  <= rx_cnt_d;
    end
  end

  // Storage arrays are never reset; validity comes from the counters.
  always_ff @(posedge clk) begin
    if (ram_we)  ram[ram_idx]     <= bus.mem_dout;
    if (tx_push) tx_mem[tx_wr_q]  <= bus.mem_dout;
    if (rx_push) rx_mem[rx_wr_q]  <= bus.rx_data;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Byte-wide memory-side responder for the CPU's cache/memory bus. It answers the single-byte-per-cycle accesses the cache controller issues on `mem_a`/`mem_dout`/`mem_wr`, returning read data on `mem_din` one cycle later. It decodes a RAM region and a UART-style I/O region, buffering outgoing bytes in a TX FIFO that raises `io_buffer_full`, and incoming bytes in an RX FIFO. It sits between the cache and the simulation RAM/UART, replacing the ad-hoc RAM model in the testbench.

## Interface

Parameters:
- `ADDR_WIDTH`, 17, RAM index width (2^17 bytes)
- `TX_DEPTH`, 8, TX FIFO entries, power of two, ≥4
- `RX_DEPTH`, 8, RX FIFO entries, power of two, ≥2

Ports:
- `clk`  in  1  clock. One clock; reset is asynchronous and active-high.
- `rst`  in  1  asynchronous reset, active-high.
- `rdy`  in  1  bus enable; when low, no bus access is performed.
- `mem_a`  in  32  byte address; only bits [17:0] are decoded.
- `mem_dout`  in  8  write data from the cache.
- `mem_wr`  in  1  1 = write, 0 = read.
- `mem_din`  out  8  registered read data.
- `io_buffer_full`  out  1  TX FIFO near-full indication to the cache.
- `tx_data`  out  8  head byte of the TX FIFO.
- `tx_valid`  out  1  TX FIFO non-empty.
- `tx_ready`  in  1  sink accepts `tx_data` this cycle.
- `rx_data`  in  8  incoming byte.
- `rx_valid`  in  1  `rx_data` is valid this cycle.
- `halt`  out  1  sticky program-end flag.

## Operation

- Decode: `io_sel = mem_a[17:16] == 2'b11`; otherwise RAM, index `mem_a[ADDR_WIDTH-1:0]`.
- Each `rdy=1` cycle performs exactly one access. `rdy=0` leaves the RAM, `mem_din`, `halt`, and bus-side FIFO pushes/pops unchanged.
- RAM write: `ram[idx] <= mem_dout`; `mem_din <= 0`.
- RAM read: `mem_din <= ram[idx]`. RAM contents are not reset.
- I/O `0x30000`:
  - Write pushes `mem_dout` into the TX FIFO.
  - Read pops the RX FIFO and returns its head byte, or 0 if the FIFO is empty.
- I/O `0x30004`:
  - Read returns `{5'b0, rx_ovf, tx_ovf, rx_nonempty}`.
  - Write sets `halt` (sticky until reset).
- Other I/O addresses: reads return 0; writes are ignored.
- TX FIFO:
  - Push is accepted if `count < TX_DEPTH` or a drain pop occurs in the same cycle. Otherwise the byte is dropped and `tx_ovf` is set (sticky).
  - Drain pop occurs when `tx_valid && tx_ready`; this is independent of `rdy`.
- RX FIFO:
  - Push on `rx_valid`, independent of `rdy`. A push to a full FIFO is dropped and sets `rx_ovf`, unless a bus pop occurs in the same cycle.
- Simultaneous push and pop on the same FIFO leaves the count unchanged; data order is preserved.
- Pointers are `log2(DEPTH)` bits wide and wrap naturally. The count is `log2(DEPTH)+1` bits.

## Timing

- Read latency is 1 cycle: the address is sampled at edge N and `mem_din` is valid after edge N until edge N+1.
- `io_buffer_full` is registered and equals `tx_count_next >= TX_DEPTH-2`. This leaves headroom for one write already committed by the cache.
- `tx_valid` and `tx_data` are combinational from FIFO state; `tx_data` equals the head entry.
- The effect of a pop on `tx_valid` is visible in the cycle after the handshake.
- Reset values: `mem_din=0`, `io_buffer_full=0`, `tx_valid=0`, `tx_data=0`, `halt=0`. Reset also clears both FIFOs and both overflow flags.
- Reset asserted mid-transfer discards FIFO contents immediately. RAM retains its contents.

## Test plan

- Write 0xA5 to 0x00010, then read 0x00010 → `mem_din=0xA5` one cycle after the read address; `mem_din=0` after the write cycle.
- Push 8 bytes (0x01..0x08) to 0x30000 with `tx_ready=0` → `io_buffer_full=1` after the 6th push; `tx_ovf=0`. A 9th push → dropped and `tx_ovf=1`. Then raise `tx_ready` → bytes 0x01..0x08 emerge in order; `io_buffer_full` clears.
- Full TX FIFO with push and drain pop in the same cycle → count stays 8; the pushed byte appears last.
- `rx_valid` with 0x41 then 0x42; read 0x30000 twice, then once more → returns 0x41, 0x42, then 0x00. Status read at 0x30004 returns 0x01 before the pops and 0x00 after.
- Hold `rdy=0` while `mem_wr=1` to 0x00020 → RAM unchanged. `mem_din` holds its value. TX drain still progresses.
- Write to 0x30004 → `halt=1`. Assert `rst` mid-stream → `halt=0`, FIFOs empty; RAM data at 0x00010 still reads back 0xA5.
